// File: rtl/vga_pkg.sv
// Shared VGA types: mode bundles, axis region encoding and a width helper.
package vga_pkg;

  typedef struct packed {
    int unsigned h_visible;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_visible;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_mode_t;

  localparam vga_mode_t VGA_800x600_60 = '{
    h_visible: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_visible: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  localparam vga_mode_t VGA_640x480_60 = '{
    h_visible: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_visible: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // Axis regions in raster order.
  typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} region_t;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with region decode; step acts as carry-in.
module vga_axis_counter #(
  parameter int unsigned VISIBLE = 800,
  parameter int unsigned FP      = 40,
  parameter int unsigned SYNC    = 128,
  parameter int unsigned BP      = 88,
  parameter int unsigned W       = vga_pkg::clog2(VISIBLE + FP + SYNC + BP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [W-1:0]     count,
  output vga_pkg::region_t region,
  output logic             wrap
);

  localparam int unsigned TOTAL       = VISIBLE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_START = W'(VISIBLE + FP);
  localparam logic [W-1:0] BACK_START = W'(VISIBLE + FP + SYNC);

  assign wrap = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  always_comb begin
    region = vga_pkg::VISIBLE;
    if (count >= BACK_START)      region = vga_pkg::BACK;
    else if (count >= SYNC_START) region = vga_pkg::SYNC;
    else if (count >= FP_START)   region = vga_pkg::FRONT;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with sync/blank delay matched to the pixel source.
// Define VGA_TPG_EN to add i_tpg_sel and the built-in test pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_800x600_60.h_visible,
  parameter int unsigned H_FP       = VGA_800x600_60.h_fp,
  parameter int unsigned H_SYNC     = VGA_800x600_60.h_sync,
  parameter int unsigned H_BP       = VGA_800x600_60.h_bp,
  parameter int unsigned V_VISIBLE  = VGA_800x600_60.v_visible,
  parameter int unsigned V_FP       = VGA_800x600_60.v_fp,
  parameter int unsigned V_SYNC     = VGA_800x600_60.v_sync,
  parameter int unsigned V_BP       = VGA_800x600_60.v_bp,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned PIX_LAT    = 1,
  localparam int unsigned HW = clog2(H_VISIBLE + H_FP + H_SYNC + H_BP),
  localparam int unsigned VW = clog2(V_VISIBLE + V_FP + V_SYNC + V_BP)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
`ifdef VGA_TPG_EN
  input  logic                     i_tpg_sel,
`endif
  input  logic [COLOR_BITS-1:0]    i_red,
  input  logic [COLOR_BITS-1:0]    i_green,
  input  logic [COLOR_BITS-1:0]    i_blue,
  output logic [HW-1:0]            o_x,
  output logic [VW-1:0]            o_y,
  output logic [HW-SCALE_LOG2-1:0] o_cell_x,
  output logic [VW-SCALE_LOG2-1:0] o_cell_y,
  output logic                     o_de_req,
  output logic [COLOR_BITS-1:0]    o_red,
  output logic [COLOR_BITS-1:0]    o_green,
  output logic [COLOR_BITS-1:0]    o_blue,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic                     o_de,
  output logic                     o_sol,
  output logic                     o_sof
);

  localparam int unsigned CELL = 1 << SCALE_LOG2;

  if (H_VISIBLE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_VISIBLE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      (H_VISIBLE % CELL) != 0 || (V_VISIBLE % CELL) != 0 ||
      PIX_LAT > 8 || COLOR_BITS == 0) begin : g_bad_params
    $error("vga_timing_gen: illegal timing/scale parameters");
  end

  region_t h_region, v_region;
  logic    h_wrap, v_wrap;
  logic    at_sol, at_sof;
  logic    raw_hs, raw_vs, raw_de;
  logic    tap_hs, tap_vs, tap_de;
  logic [COLOR_BITS-1:0] red_src, green_src, blue_src;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h_axis (
    .clk(i_clk), .rst_n(i_rst_n), .step(i_en),
    .count(o_x), .region(h_region), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v_axis (
    .clk(i_clk), .rst_n(i_rst_n), .step(i_en & h_wrap),
    .count(o_y), .region(v_region), .wrap(v_wrap)
  );

  assign o_cell_x = o_x[HW-1:SCALE_LOG2];
  assign o_cell_y = o_y[VW-1:SCALE_LOG2];
  assign raw_hs   = (h_region == SYNC);
  assign raw_vs   = (v_region == SYNC);
  assign raw_de   = (h_region == VISIBLE) && (v_region == VISIBLE);
  assign o_de_req = raw_de;

  // Flags track "counter sits at line/frame start"; reset parks both at 0,0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      at_sol <= 1'b1;
      at_sof <= 1'b1;
    end else if (i_en) begin
      at_sol <= h_wrap;
      at_sof <= h_wrap & v_wrap;
    end
  end

  assign o_sol = i_en & i_rst_n & at_sol;
  assign o_sof = i_en & i_rst_n & at_sof;

`ifdef VGA_TPG_EN
  localparam int unsigned PW = 3 + HW + VW;
  logic [HW-1:0] tap_x;
  logic [VW-1:0] tap_y;
  logic [PW-1:0] raw, tap;
  assign raw   = {raw_de, raw_hs, raw_vs, o_x, o_y};
  assign tap_x = tap[HW+VW-1:VW];
  assign tap_y = tap[VW-1:0];
`else
  localparam int unsigned PW = 3;
  logic [PW-1:0] raw, tap;
  assign raw = {raw_de, raw_hs, raw_vs};
`endif

  assign {tap_de, tap_hs, tap_vs} = tap[PW-1:PW-3];

  // Active-high delay line; all-zero is the inactive (blanked, no sync) state.
  if (PIX_LAT == 0) begin : g_no_delay
    assign tap = raw;
  end else begin : g_delay
    logic [PIX_LAT-1:0][PW-1:0] dly;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        dly <= '0;
      end else if (i_en) begin
        dly[0] <= raw;
        for (int k = 1; k < PIX_LAT; k++) dly[k] <= dly[k-1];
      end
    end
    assign tap = dly[PIX_LAT-1];
  end

  always_comb begin
    red_src   = i_red;
    green_src = i_green;
    blue_src  = i_blue;
`ifdef VGA_TPG_EN
    if (i_tpg_sel) begin
      red_src   = COLOR_BITS'(tap_x >> SCALE_LOG2) & COLOR_BITS'(tap_y >> SCALE_LOG2);
      green_src = COLOR_BITS'(tap_x >> (SCALE_LOG2 + 3));
      blue_src  = COLOR_BITS'(tap_y >> (SCALE_LOG2 + 3));
    end
`endif
  end

  // Output stage: polarity applied here, colour blanked outside delayed de.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync <= !H_SYNC_POL;
      o_vsync <= !V_SYNC_POL;
      o_de    <= 1'b0;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else if (i_en) begin
      o_hsync <= tap_hs ? H_SYNC_POL : !H_SYNC_POL;
      o_vsync <= tap_vs ? V_SYNC_POL : !V_SYNC_POL;
      o_de    <= tap_de;
      o_red   <= tap_de ? red_src   : '0;
      o_green <= tap_de ? green_src : '0;
      o_blue  <= tap_de ? blue_src  : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with colour pipeline alignment, sitting between the pixel-clock PLL and the board's RGB/sync pins. It produces programmable-polarity hsync/vsync, a data-enable, pixel/cell coordinates and frame/line strobes. It delays sync and blanking to match a pixel source of fixed latency, and it blanks colour outside the visible area. It generalises the fixed 800x600@60 4x4-downscaled generator to any mode, colour depth and downscale factor.

## Interface
- H_VISIBLE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width
- H_BP, 88, horizontal back porch
- V_VISIBLE, 600, visible lines; V_FP 1; V_SYNC 4; V_BP 23 (lines)
- H_SYNC_POL / V_SYNC_POL, 1 / 1, active level of hsync / vsync
- COLOR_BITS, 2, bits per colour channel
- SCALE_LOG2, 2, cell size is 2^SCALE_LOG2 pixels in each axis
- PIX_LAT, 1, pixel-source latency in cycles, from coordinates to i_red/i_green/i_blue (0..8)
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  pixel-clock enable; all state advances only when high
- i_red/i_green/i_blue  in  COLOR_BITS  pixel colour for coordinates issued PIX_LAT enabled cycles earlier
- o_x  out  clog2(H_total)  current horizontal count; o_y  out  clog2(V_total)  current line
- o_cell_x / o_cell_y  out  widths minus SCALE_LOG2  o_x>>SCALE_LOG2, o_y>>SCALE_LOG2
- o_de_req  out  1  coordinates are inside the visible area (undelayed)
- o_red/o_green/o_blue  out  COLOR_BITS  registered colour, zero when blanked
- o_hsync, o_vsync, o_de  out  1  delayed, aligned with colour outputs
- o_sol, o_sof  out  1  one-enabled-cycle strobes at x=0 (any line) and at x=0,y=0

## Operation
- H_total = H_VISIBLE+H_FP+H_SYNC+H_BP; V_total likewise. Region order on each axis: visible, front porch, sync, back porch.
- Horizontal counter 0..H_total-1 wraps to 0 and increments the vertical counter. Vertical counter 0..V_total-1 wraps to 0.
- o_de_req = (x < H_VISIBLE) && (y < V_VISIBLE).
- Raw hsync is active when H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC. Raw vsync uses the same rule on y, evaluated per line, so it is asserted for whole lines.
- Raw hsync, raw vsync and de pass through a delay line of PIX_LAT enabled cycles, then one output register. The colour input is registered in the same stage: o_red = delayed_de ? i_red : 0.
- When i_en is low, counters, delay line and output registers all hold. The strobes are gated to 0 while i_en is low.
- Reset (async assert, sync deassert by the upstream reset synchroniser):
  - counters 0
  - delay line filled with inactive values
  - o_hsync = !H_SYNC_POL, o_vsync = !V_SYNC_POL
  - o_de, colours, o_sol, o_sof = 0
- Reset mid-frame restarts at x=0, y=0. The first o_sof follows the first enabled cycle after release.

## Timing
- Counter outputs (o_x, o_y, cells, o_de_req, o_sol, o_sof) are registered state: a value appears in the same cycle as the count.
- Sync, de and colour appear PIX_LAT+1 enabled cycles after the corresponding o_x/o_y.
- Wrap: on the cycle where x=H_total-1 and y=V_total-1, the next enabled cycle has x=0, y=0 and o_sof=1.
- The parameters must satisfy every region ≥1 and H_VISIBLE, V_VISIBLE divisible by 2^SCALE_LOG2. A violation is an elaboration error via a generate-time check.

## Configuration
- VGA_TPG_EN defined:
  - adds input i_tpg_sel (1 bit).
  - While i_tpg_sel=1, the colour stage ignores i_red/i_green/i_blue. It uses an internal pattern computed from the delayed coordinates:
    - red = cell_x[COLOR_BITS-1:0] & cell_y[COLOR_BITS-1:0]
    - green = x bits [SCALE_LOG2+3 +: COLOR_BITS]
    - blue = the same bits of y
  - The pattern is still blanked outside de.
- Undefined: no port, no pattern logic.

## Structure
- Package vga_pkg: mode parameter bundles (VGA_800x600_60, VGA_640x480_60), region enum (VISIBLE, FRONT, SYNC, BACK), and a clog2 helper for the counter widths.
- One sub-module, vga_axis_counter, instantiated twice (horizontal; vertical with carry-in). Parameters: VISIBLE/FP/SYNC/BP. Outputs: count, region, wrap.

## Test plan
- Default mode, i_en=1: hsync period is 1056 cycles with a high width of 128, rising at x=840. The vsync high width is 4*1056 cycles, and the frame is 628*1056 = 663168 cycles.
- H_SYNC_POL=0, V_SYNC_POL=0: during reset o_hsync=1 and o_vsync=1. The sync pulses go low for the same windows as above.
- PIX_LAT=3, i_red driven from a 3-cycle delay of o_x[1:0]: o_red equals o_x[1:0] of 4 cycles earlier whenever o_de=1, and is 0 at x≥800.
- i_en toggled 1-0-1 every cycle: frame length doubles to 1326336 cycles; o_sof is a single enabled cycle.
- Assert i_rst_n low at x=500, y=300 for 3 cycles: outputs take their reset values immediately (async), and after release o_sof=1 at x=0, y=0.
- VGA_TPG_EN, i_tpg_sel=1: at x=4, y=4, o_red=2'b01; at x=800, o_red=0.
